// File: rtl/zxuno_regbus_master_pkg.sv
// rtl/zxuno_regbus_master_pkg.sv - shared constants for the ZX-Uno register bus master
// Holds the Z80 I/O port addresses, well-known register numbers and the
// aux-requester FSM state encodings.
package zxuno_regbus_master_pkg;

    // Z80 I/O ports of the register bus
    localparam logic [15:0] ZXUNO_ADDR_PORT = 16'hFC3B;
    localparam logic [15:0] ZXUNO_DATA_PORT = 16'hFD3B;

    // Register numbers used by responders and the boot/hotkey masters
    localparam logic [7:0] REG_MASTERCONF  = 8'h00;
    localparam logic [7:0] REG_MASTERMAPPER = 8'h01;
    localparam logic [7:0] REG_SCANDBLCTRL = 8'h0B;
    localparam logic [7:0] REG_COREID      = 8'hFF;

    // Aux FSM states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_ACK    = 2'd2;

endpackage

// File: rtl/zxuno_io_strobe.sv
// rtl/zxuno_io_strobe.sv - armed one-shot write pulse and level read enable for one Z80 port
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   iorq_n, rd_n, wr_n Z80 strobes
//   port_hit           IORQ active and address matches this port
//   enable             bus free to issue a strobe this cycle
//   din                Z80 write data
//   wr_pulse, wr_data  registered single-cycle write strobe and its data
//   rd_en              combinational read enable, level for the whole cycle
module zxuno_io_strobe (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       port_hit,
    input  logic       enable,
    input  logic [7:0] din,
    output logic       wr_pulse,
    output logic [7:0] wr_data,
    output logic       rd_en
);

    logic wr_armed;

    // One pulse per Z80 write cycle: disarm on fire, re-arm only once IORQ
    // has gone inactive. While not enabled the fire is simply postponed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_armed <= 1'b1;
            wr_pulse <= 1'b0;
            wr_data  <= 8'h00;
        end else begin
            wr_pulse <= 1'b0;
            if (iorq_n) begin
                wr_armed <= 1'b1;
            end else if (port_hit && !wr_n && wr_armed && enable) begin
                wr_pulse <= 1'b1;
                wr_data  <= din;
                wr_armed <= 1'b0;
            end
        end
    end

    assign rd_en = port_hit && !rd_n && enable;

endmodule

// File: rtl/zxuno_regbus_master.sv
// rtl/zxuno_regbus_master.sv - ZX-Uno register bus initiator for the Z80 and an aux requester
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   a, iorq_n, rd_n, wr_n, din      Z80 bus
//   dout, oe                        read data and its valid to the CPU data mux
//   zxuno_addr, zxuno_regrd,
//   zxuno_regwr, regbus_wdata       register bus to the responders
//   resp_oe, resp_dout              OR-combined responder read return
//   aux_req, aux_we, aux_addr,
//   aux_wdata, aux_ack, aux_rdata   single-access requester port (boot loader, hotkeys)
module zxuno_regbus_master
    import zxuno_regbus_master_pkg::*;
#(
    parameter logic [15:0] ADDR_PORT = ZXUNO_ADDR_PORT,
    parameter logic [15:0] DATA_PORT = ZXUNO_DATA_PORT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        oe,
    output logic [7:0]  zxuno_addr,
    output logic        zxuno_regrd,
    output logic        zxuno_regwr,
    output logic [7:0]  regbus_wdata,
    input  logic        resp_oe,
    input  logic [7:0]  resp_dout,
    input  logic        aux_req,
    input  logic        aux_we,
    input  logic [7:0]  aux_addr,
    input  logic [7:0]  aux_wdata,
    output logic        aux_ack,
    output logic [7:0]  aux_rdata
);

    logic [7:0] addr_latch;
    logic [1:0] state;
    logic       aux_we_q;
    logic [7:0] aux_addr_q;
    logic [7:0] aux_wdata_q;
    logic       addr_hit;
    logic       data_hit;
    logic       cpu_wr_pulse;
    logic [7:0] cpu_wdata;
    logic       cpu_rd_en;
    logic       in_access;
    logic [7:0] resp_data;

    assign addr_hit  = !iorq_n && (a == ADDR_PORT);
    assign data_hit  = !iorq_n && (a == DATA_PORT);
    assign in_access = (state == ST_ACCESS);
    assign resp_data = resp_oe ? resp_dout : 8'hFF;

    // Reloaded on every clock of the OUT cycle; harmless since din is stable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_latch <= 8'h00;
        end else if (addr_hit && !wr_n) begin
            addr_latch <= din;
        end
    end

    // CPU strobes only issue in IDLE, so an aux access in flight defers them.
    zxuno_io_strobe u_data_strobe (
        .clk      (clk),
        .rst_n    (rst_n),
        .iorq_n   (iorq_n),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .port_hit (data_hit),
        .enable   (state == ST_IDLE),
        .din      (din),
        .wr_pulse (cpu_wr_pulse),
        .wr_data  (cpu_wdata),
        .rd_en    (cpu_rd_en)
    );

    // Aux requester: granted only while the Z80 is off the I/O bus. The
    // request fields are captured at grant so ACCESS drives stable values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            aux_we_q    <= 1'b0;
            aux_addr_q  <= 8'h00;
            aux_wdata_q <= 8'h00;
            aux_rdata   <= 8'hFF;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (aux_req && iorq_n && !cpu_wr_pulse) begin
                        state       <= ST_ACCESS;
                        aux_we_q    <= aux_we;
                        aux_addr_q  <= aux_addr;
                        aux_wdata_q <= aux_wdata;
                    end
                end
                ST_ACCESS: begin
                    if (!aux_we_q) begin
                        aux_rdata <= resp_data;
                    end
                    state <= ST_ACK;
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign aux_ack      = (state == ST_ACK);
    assign zxuno_addr   = in_access ? aux_addr_q : addr_latch;
    assign regbus_wdata = in_access ? aux_wdata_q : cpu_wdata;
    assign zxuno_regwr  = cpu_wr_pulse || (in_access && aux_we_q);
    assign zxuno_regrd  = cpu_rd_en || (in_access && !aux_we_q);

    // CPU read mux: both ports answer for the whole IN cycle.
    always_comb begin
        oe   = 1'b0;
        dout = 8'hFF;
        if (addr_hit && !rd_n) begin
            oe   = 1'b1;
            dout = addr_latch;
        end else if (data_hit && !rd_n) begin
            oe   = 1'b1;
            dout = resp_data;
        end
    end

endmodule

// File: doc/zxuno_regbus_master.md
Name: zxuno_regbus_master

Overview:
Initiator side of the ZX-Uno internal register bus. It decodes Z80 I/O cycles on the register address port (0xFC3B) and data port (0xFD3B). From those it drives zxuno_addr, zxuno_regrd, zxuno_regwr and the write data to every register responder (video/speed control, etc.), and it returns the OR-combined responder read data to the CPU. A second requester port (aux) lets non-CPU masters, such as the boot loader or keyboard hotkey sequencer, issue single register reads and writes, arbitrated against the CPU.

Parameters:
ADDR_PORT, 16'hFC3B, Z80 I/O address of the register-number latch
DATA_PORT, 16'hFD3B, Z80 I/O address of the register data window

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active low
a  in  16  Z80 address bus
iorq_n  in  1  Z80 IORQ
rd_n  in  1  Z80 RD
wr_n  in  1  Z80 WR
din  in  8  Z80 data bus (CPU write data)
dout  out  8  read data to CPU data mux
oe  out  1  dout valid, request CPU data mux
zxuno_addr  out  8  register number to responders
zxuno_regrd  out  1  register read enable to responders
zxuno_regwr  out  1  register write strobe to responders
regbus_wdata  out  8  write data to responders
resp_oe  in  1  OR of responder oe
resp_dout  in  8  muxed responder dout
aux_req  in  1  aux access request (level)
aux_we  in  1  aux access is a write
aux_addr  in  8  aux register number
aux_wdata  in  8  aux write data
aux_ack  out  1  aux access complete, 1-cycle pulse
aux_rdata  out  8  aux read result, valid with aux_ack

Behaviour:
- Reset (rst_n=0 at posedge): addr latch 0x00; state IDLE; wr_armed=1; aux_ack=0; aux_rdata=0xFF; zxuno_regwr=0. A reset during an aux access aborts it with no ack.
- CPU cycle definitions:
  - cpu_io = !iorq_n and a in {ADDR_PORT, DATA_PORT}.
  - cpu_wr = cpu_io and !wr_n.
  - cpu_rd = cpu_io and !rd_n.
- Address latch:
  - A CPU write to ADDR_PORT loads din on every clock of the cycle. This is idempotent.
  - A CPU read of ADDR_PORT gives oe=1, dout=latch, combinationally. No bus strobe is issued.
- Data port write:
  - zxuno_regwr is a single-cycle pulse per Z80 write cycle, registered. It asserts on the first posedge where cpu_wr to DATA_PORT is true and wr_armed=1, and wr_armed then clears.
  - wr_armed re-sets when iorq_n is sampled high.
  - During the pulse, regbus_wdata carries the din sampled at that same posedge, and zxuno_addr equals the latch.
- Data port read:
  - zxuno_regrd is combinational and held at level for the whole cpu_rd to DATA_PORT while state=IDLE.
  - oe=1 for the whole cycle. dout=resp_dout if resp_oe=1, else 0xFF.
- Default outputs: when neither port is addressed, oe=0 and dout=0xFF.
- Aux FSM, states IDLE, ACCESS, ACK:
  - IDLE -> ACCESS when aux_req=1, iorq_n=1 and no CPU write pulse is pending this cycle. The CPU has priority: any Z80 I/O cycle in progress stalls the grant.
  - ACCESS, one cycle:
    - zxuno_addr=aux_addr.
    - If aux_we: zxuno_regwr=1 and regbus_wdata=aux_wdata.
    - Otherwise: zxuno_regrd=1, and aux_rdata captures resp_dout (0xFF if resp_oe=0) at the end of the cycle.
    - The CPU address latch is untouched.
  - ACK: aux_ack=1 for one cycle, then IDLE.
  - Latency from aux_req sampled high to aux_ack is 2 clocks.
  - If aux_req is still high in the first IDLE cycle after ACK, a new access starts. Requesters drop req upon ack.
- Simultaneous events:
  - A CPU cycle that begins while the FSM is in ACCESS or ACK is not lost. Its write pulse or read enable is deferred until IDLE, at most 2 clocks. Z80 I/O cycles are many clocks long, so this is safe.
  - A CPU address write and an aux access may occur in the same period; the aux path never alters the latch.
- Widths: all data is 8 bits and the latch wraps naturally. Register number 0xFF is not special.

Decomposition:
- Shared package/include (config.vh):
  - ADDR_PORT and DATA_PORT constants.
  - Register number constants, SCANDBLCTRL among them.
  - Aux FSM state encodings.
- One natural sub-module: zxuno_io_strobe. It takes iorq_n, rd_n, wr_n, a and a port match, and produces the armed one-shot write pulse and the level read enable.

Test Plan:
- Reset: hold rst_n=0 for 2 clocks -> latch 0x00, zxuno_regwr=0, aux_ack=0, aux_rdata=0xFF, oe=0.
- OUT (0xFC3B),0x0B, then OUT (0xFD3B),0x5A with iorq_n/wr_n low for 8 clocks -> zxuno_addr=0x0B, zxuno_regwr high for exactly 1 clock, regbus_wdata=0x5A. A second OUT gives a second pulse.
- IN (0xFC3B) -> oe=1, dout=0x0B for the whole cycle. IN (0xFD3B) with resp_oe=1, resp_dout=0x83 -> zxuno_regrd level, dout=0x83. With resp_oe=0 -> dout=0xFF, oe=1.
- Aux write, addr 0x0B, wdata 0x07, bus idle -> ACCESS 1 clock after req with regwr=1 and zxuno_addr=0x0B. aux_ack 2 clocks after req. Latch still 0x0B after a prior latch write of 0x0B; with a prior latch of 0x22, the latch stays 0x22.
- Aux read asserted during a CPU OUT to 0xFD3B -> no grant until iorq_n is high. The CPU pulse occurs once. Aux then returns aux_rdata=resp_dout (e.g. 0x3C) with ack.
- rst_n low during ACCESS -> next state IDLE, no aux_ack, aux_rdata=0xFF.
